// File: rtl/edge_event_arbiter_if.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter_if
// Event handshake bundle between the edge event arbiter and its consumer.
//   evt_valid : an event is being offered
//   evt_id    : channel index of the offered event
//   evt_ready : consumer accepts the event when evt_valid & evt_ready
// Modports:
//   master : event producer (the arbiter)
//   slave  : event consumer
// -----------------------------------------------------------------------------
interface edge_event_arbiter_if #(
   parameter int ID_W = 2
);
   logic            evt_valid;
   logic [ID_W-1:0] evt_id;
   logic            evt_ready;

   modport master (output evt_valid, output evt_id, input evt_ready);
   modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
// Multi-channel rising-edge event scheduler. Each input line has a rising-edge
// detector and a sticky pending flag; a round-robin arbiter offers pending
// events one at a time on a shared valid/ready port. Per-channel sticky
// overflow flags record edges lost while that channel was already pending.
//
// Optional build macro:
//   EDGE_ARB_SYNC_EN : insert a 2-flop synchronizer per input bit ahead of the
//                      edge detector (input-to-valid latency grows 2 -> 4).
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   i_in       : N_CH level inputs monitored for rising edges
//   evt_if     : event handshake (master modport: evt_valid, evt_id, evt_ready)
//   o_pending  : per-channel pending flags (register view)
//   o_overflow : per-channel sticky overflow flags
//   i_clr_ovf  : one-cycle pulse clearing all overflow flags
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
   parameter int N_CH = 4,
   parameter int ID_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CH-1:0]      i_in,
   edge_event_arbiter_if.master evt_if,
   output logic [N_CH-1:0]      o_pending,
   output logic [N_CH-1:0]      o_overflow,
   input  logic                 i_clr_ovf
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OFFER = 1'b1;

   logic [N_CH-1:0] w_in;
   logic [N_CH-1:0] r_in_q;
   logic [N_CH-1:0] w_edge;
   logic [N_CH-1:0] r_pending;
   logic [N_CH-1:0] r_overflow;
   logic [N_CH-1:0] w_pending_nxt;
   logic [N_CH-1:0] w_overflow_nxt;
   logic [N_CH-1:0] w_acc_vec;
   logic [0:0]      r_state;
   logic            r_evt_valid;
   logic [ID_W-1:0] r_evt_id;
   logic [ID_W-1:0] r_rr_ptr;
   logic [ID_W-1:0] w_rr_nxt;
   logic [ID_W-1:0] w_pick;
   logic            w_found;
   logic            w_accept;
   int              w_idx;

`ifdef EDGE_ARB_SYNC_EN
   logic [N_CH-1:0] r_sync1;
   logic [N_CH-1:0] r_sync2;

   // Two-flop synchronizer for asynchronous inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_in = r_sync2;
`else
   assign w_in = i_in;
`endif

   assign w_edge   = w_in & ~r_in_q;
   // Handshake only counts while an offer is actually on the port
   assign w_accept = (r_state == ST_OFFER) & r_evt_valid & evt_if.evt_ready;

   // Explicit wrap keeps rr_ptr inside 0..N_CH-1 for non-power-of-2 N_CH
   always_comb begin
      if (r_evt_id == ID_W'(N_CH - 1)) begin
         w_rr_nxt = '0;
      end else begin
         w_rr_nxt = r_evt_id + {{(ID_W-1){1'b0}}, 1'b1};
      end
   end

   // Round-robin search: first pending bit at rr_ptr, rr_ptr+1, ... mod N_CH
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = 0;
      for (int k = 0; k < N_CH; k++) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= N_CH) begin
            w_idx = w_idx - N_CH;
         end else begin
            w_idx = w_idx;
         end
         if (!w_found && r_pending[w_idx]) begin
            w_found = 1'b1;
            w_pick  = ID_W'(w_idx);
         end else begin
            w_found = w_found;
         end
      end
   end

   // Pending/overflow next state; an edge wins over its own acceptance
   always_comb begin
      w_acc_vec      = '0;
      w_pending_nxt  = r_pending;
      w_overflow_nxt = r_overflow;
      for (int i = 0; i < N_CH; i++) begin
         w_acc_vec[i] = w_accept & (r_evt_id == ID_W'(i));
         if (w_edge[i]) begin
            w_pending_nxt[i] = 1'b1;
         end else if (w_acc_vec[i]) begin
            w_pending_nxt[i] = 1'b0;
         end else begin
            w_pending_nxt[i] = r_pending[i];
         end
         if (w_edge[i] & r_pending[i] & ~w_acc_vec[i]) begin
            w_overflow_nxt[i] = 1'b1;
         end else if (i_clr_ovf) begin
            w_overflow_nxt[i] = 1'b0;
         end else begin
            w_overflow_nxt[i] = r_overflow[i];
         end
      end
   end

   // Edge-detect history and per-channel flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_q     <= '0;
         r_pending  <= '0;
         r_overflow <= '0;
      end else begin
         r_in_q     <= w_in;
         r_pending  <= w_pending_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

   // Offer FSM: offered channel is frozen until the handshake completes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_evt_valid <= 1'b0;
         r_evt_id    <= '0;
         r_rr_ptr    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_evt_id    <= w_pick;
                  r_evt_valid <= 1'b1;
                  r_state     <= ST_OFFER;
               end else begin
                  r_evt_valid <= 1'b0;
               end
            end
            ST_OFFER: begin
               if (w_accept) begin
                  r_rr_ptr    <= w_rr_nxt;
                  r_evt_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end else begin
                  r_evt_valid <= 1'b1;
               end
            end
            default: begin
               r_evt_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign evt_if.evt_valid = r_evt_valid;
   assign evt_if.evt_id    = r_evt_id;
   assign o_pending        = r_pending;
   assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_edge_event_arbiter
// Scoreboard bench: a behavioural model predicts each offered channel and
// pushes it into a queue; a monitor pops and compares on every DUT handshake.
// Register views (pending, overflow, valid, id) are compared every cycle.
// Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_edge_event_arbiter;
   localparam int N_CH = 4;
   localparam int ID_W = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N_CH-1:0] in_s = '0;
   logic            clr_ovf = 1'b0;
   logic [N_CH-1:0] pending;
   logic [N_CH-1:0] overflow;

   edge_event_arbiter_if #(.ID_W(ID_W)) evt_if ();

   edge_event_arbiter #(.N_CH(N_CH), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_in       (in_s),
      .evt_if     (evt_if),
      .o_pending  (pending),
      .o_overflow (overflow),
      .i_clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model state
   logic [N_CH-1:0] m_inq;
   logic [N_CH-1:0] m_pend;
   logic [N_CH-1:0] m_ovf;
   bit              m_valid;
   int              m_id;
   int              m_rr;
   int              expq[$];
   int              got[$];
   int              got_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: steps once per clock from the spec's rules
   always @(posedge clk) begin
      logic [N_CH-1:0] e;
      logic [N_CH-1:0] np;
      logic [N_CH-1:0] no;
      bit acc;
      bit a;
      cyc++;
      if (rst) begin
         m_inq = '0; m_pend = '0; m_ovf = '0;
         m_valid = 0; m_id = 0; m_rr = 0;
         expq.delete();
      end else begin
         e   = in_s & ~m_inq;
         acc = m_valid && (evt_if.evt_ready === 1'b1);
         np  = m_pend;
         no  = m_ovf;
         for (int ch = 0; ch < N_CH; ch++) begin
            a = acc && (m_id == ch);
            if (e[ch] && m_pend[ch] && !a) no[ch] = 1'b1;
            else if (clr_ovf) no[ch] = 1'b0;
            if (e[ch]) np[ch] = 1'b1;
            else if (a) np[ch] = 1'b0;
         end
         if (acc) begin
            m_rr    = (m_id + 1) % N_CH;
            m_valid = 0;
         end else if (!m_valid) begin
            for (int k = 0; k < N_CH; k++) begin
               if (!m_valid && m_pend[(m_rr + k) % N_CH]) begin
                  m_valid = 1;
                  m_id    = (m_rr + k) % N_CH;
                  expq.push_back(m_id);
               end
            end
         end
         m_pend = np;
         m_ovf  = no;
         m_inq  = in_s;
      end
   end

   // Monitor: per-cycle register compare plus handshake scoreboard
   always @(negedge clk) begin
      int exp_id;
      if (!rst && cyc > 0) begin
         chk("evt_valid", {31'd0, evt_if.evt_valid}, {31'd0, m_valid});
         chk("pending", {28'd0, pending}, {28'd0, m_pend});
         chk("overflow", {28'd0, overflow}, {28'd0, m_ovf});
         if (m_valid) chk("evt_id", {30'd0, evt_if.evt_id}, m_id);
         if (evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
            if (expq.size() == 0) begin
               chk("hs_unexpected", 32'd1, 32'd0);
            end else begin
               exp_id = expq.pop_front();
               chk("hs_id", {30'd0, evt_if.evt_id}, exp_id);
            end
            got.push_back(int'(evt_if.evt_id));
            got_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input int budget);
      int k;
      k = 0;
      while (evt_if.evt_valid !== 1'b1 && k < budget) begin
         tick(1);
         k++;
      end
      chk("wait_valid", {31'd0, evt_if.evt_valid}, 32'd1);
   endtask

   task automatic chk_order(input string name, input int a0, input int a1, input int a2);
      chk({name, "_n"}, got.size(), 3);
      if (got.size() == 3) begin
         chk({name, "_0"}, got[0], a0);
         chk({name, "_1"}, got[1], a1);
         chk({name, "_2"}, got[2], a2);
         chk({name, "_gap1"}, got_cyc[1] - got_cyc[0], 2);
         chk({name, "_gap2"}, got_cyc[2] - got_cyc[1], 2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      evt_if.evt_ready = 1'b1;
      // reset
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      chk("rst_valid", {31'd0, evt_if.evt_valid}, 32'd0);
      chk("rst_pending", {28'd0, pending}, 32'd0);
      chk("rst_overflow", {28'd0, overflow}, 32'd0);

      // single event on channel 2
      in_s[2] = 1'b1;
      tick(1);
      chk("single_pend", {31'd0, pending[2]}, 32'd1);
      chk("single_not_yet", {31'd0, evt_if.evt_valid}, 32'd0);
      tick(1);
      chk("single_valid", {31'd0, evt_if.evt_valid}, 32'd1);
      chk("single_id", {30'd0, evt_if.evt_id}, 32'd2);
      tick(1);
      chk("single_cleared", {31'd0, pending[2]}, 32'd0);
      tick(6);
      chk("single_quiet", {31'd0, evt_if.evt_valid}, 32'd0);

      // round-robin from rr_ptr = 0
      rst = 1'b1; in_s = '0;
      tick(1);
      rst = 1'b0;
      tick(1);
      got.delete(); got_cyc.delete();
      in_s = 4'b1011;
      tick(10);
      chk_order("rr0", 0, 1, 3);

      // serve channel 1 alone so rr_ptr = 2, then same burst
      in_s = 4'b0000;
      tick(1);
      in_s[1] = 1'b1;
      tick(6);
      in_s = 4'b0000;
      tick(1);
      got.delete(); got_cyc.delete();
      in_s = 4'b1011;
      tick(10);
      chk_order("rr2", 3, 0, 1);

      // backpressure on channel 1 while channel 0 edges
      in_s = 4'b0000;
      evt_if.evt_ready = 1'b0;
      tick(1);
      got.delete(); got_cyc.delete();
      in_s[1] = 1'b1;
      wait_valid(10);
      chk("bp_id0", {30'd0, evt_if.evt_id}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         in_s[0] = ~in_s[0];
         tick(1);
         chk("bp_hold_valid", {31'd0, evt_if.evt_valid}, 32'd1);
         chk("bp_hold_id", {30'd0, evt_if.evt_id}, 32'd1);
      end
      evt_if.evt_ready = 1'b1;
      tick(6);
      chk("bp_n", got.size(), 2);
      if (got.size() == 2) begin
         chk("bp_first", got[0], 1);
         chk("bp_second", got[1], 0);
      end

      // overflow on channel 3
      in_s = 4'b0000;
      evt_if.evt_ready = 1'b0;
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      in_s[3] = 1'b1;
      wait_valid(10);
      chk("ovf_id", {30'd0, evt_if.evt_id}, 32'd3);
      in_s[3] = 1'b0;
      tick(1);
      in_s[3] = 1'b1;
      tick(1);
      chk("ovf_set", {31'd0, overflow[3]}, 32'd1);
      evt_if.evt_ready = 1'b1;
      tick(1);
      chk("ovf_after_acc", {31'd0, overflow[3]}, 32'd1);
      tick(1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      chk("ovf_cleared", {31'd0, overflow[3]}, 32'd0);
      // clear and set in the same cycle
      evt_if.evt_ready = 1'b0;
      in_s[3] = 1'b0;
      tick(1);
      in_s[3] = 1'b1;
      wait_valid(10);
      in_s[3] = 1'b0;
      tick(1);
      in_s[3] = 1'b1;
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      chk("ovf_set_wins", {31'd0, overflow[3]}, 32'd1);
      evt_if.evt_ready = 1'b1;
      tick(4);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;

      // edge on the offered channel exactly at the handshake
      evt_if.evt_ready = 1'b0;
      in_s = 4'b0000;
      tick(1);
      got.delete(); got_cyc.delete();
      in_s[2] = 1'b1;
      wait_valid(10);
      chk("same_id", {30'd0, evt_if.evt_id}, 32'd2);
      in_s[2] = 1'b0;
      in_s[0] = 1'b1;
      tick(1);
      evt_if.evt_ready = 1'b1;
      in_s[2] = 1'b1;
      tick(1);
      chk("same_pend", {31'd0, pending[2]}, 32'd1);
      chk("same_ovf", {31'd0, overflow[2]}, 32'd0);
      tick(8);
      chk("same_n", got.size(), 3);
      if (got.size() == 3) begin
         chk("same_0", got[0], 2);
         chk("same_1", got[1], 0);
         chk("same_2", got[2], 2);
      end

      // reset in the middle of an offer
      evt_if.evt_ready = 1'b0;
      in_s = 4'b0000;
      tick(1);
      in_s = 4'b1011;
      tick(2);
      chk("mid_pend", {28'd0, pending}, 32'd11);
      chk("mid_valid", {31'd0, evt_if.evt_valid}, 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid_rst_valid", {31'd0, evt_if.evt_valid}, 32'd0);
      chk("mid_rst_pend", {28'd0, pending}, 32'd0);
      chk("mid_rst_ovf", {28'd0, overflow}, 32'd0);
      got.delete(); got_cyc.delete();
      evt_if.evt_ready = 1'b1;
      tick(10);
      chk_order("mid_retrig", 0, 1, 3);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         in_s             = N_CH'($urandom);
         evt_if.evt_ready = ($urandom_range(0, 2) != 0);
         clr_ovf          = ($urandom_range(0, 15) == 0);
         rst              = ($urandom_range(0, 299) == 0);
         tick(1);
      end
      rst = 1'b0;
      clr_ovf = 1'b0;
      evt_if.evt_ready = 1'b1;
      tick(20);
      chk("drain_empty", expq.size(), 0);
      chk("drain_idle", {31'd0, evt_if.evt_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel rising-edge event scheduler.
- Each of N_CH input lines gets a synchronous rising-edge detector and a sticky pending flag.
- A round-robin arbiter offers pending events one at a time on a shared valid/ready event port, so several edge sources can share one downstream consumer (interrupt/event handler).
- Per-channel overflow flags record edges lost while a previous event on that channel was still pending.

Parameters:
- N_CH, 4, number of input channels; must be >= 2.
- ID_W, 2, width of the event ID; must equal ceil(log2(N_CH)).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in  input  N_CH  level inputs monitored for rising edges.
- evt_valid  output  1  an event is offered on evt_id.
- evt_id  output  ID_W  channel index of the offered event.
- evt_ready  input  1  consumer accepts the event when evt_valid & evt_ready.
- pending  output  N_CH  per-channel pending flags, direct register view.
- overflow  output  N_CH  per-channel sticky overflow flags.
- clr_ovf  input  1  clears all overflow flags, one-cycle pulse.

Behaviour:
- Reset values: in_q, pending, overflow, evt_valid, evt_id and rr_ptr are all 0; FSM in IDLE.
  - Any output state is abandoned on rst.
  - evt_valid is low in the cycle after the rst edge, regardless of the handshake.
- Edge detect:
  - in_q registers in every cycle; edge[i] = in[i] & ~in_q[i].
  - Because in_q resets to 0, an input that is high when rst deasserts produces an edge on the first non-reset clock.
- Pending, per channel, evaluated in priority order each clock:
  - rst -> 0.
  - edge[i] -> 1.
  - Handshake accepting channel i -> 0.
  - Otherwise hold.
  - Consequence: an edge in the same cycle as its own acceptance leaves pending = 1, with no overflow.
- Overflow, per channel:
  - Set when edge[i] & pending[i] & ~(accept of channel i this cycle).
  - Otherwise cleared by clr_ovf; set has priority over clear in the same cycle.
  - Never cleared by the handshake.
- FSM states IDLE and OFFER:
  - IDLE, some pending bit set:
    - Choose the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_CH.
    - Register evt_id = chosen index and evt_valid = 1; go to OFFER.
  - IDLE, no pending bit set: stay in IDLE with evt_valid = 0.
  - OFFER:
    - evt_id and evt_valid are held stable until evt_valid & evt_ready.
    - On handshake: clear pending[evt_id] as above, set rr_ptr = (evt_id+1) mod N_CH, set evt_valid = 0, go to IDLE.
  - evt_ready while in IDLE is ignored.
  - The offered channel never changes while in OFFER, even if other channels become pending.
- Latency and throughput:
  - Input sampled high at clock k -> pending visible after k -> evt_valid high after k+1, i.e. 2 cycles.
  - Maximum throughput is 1 event per 2 cycles: OFFER and IDLE alternate.
- Fairness: after a channel is served it has lowest priority. With all channels pending continuously, service order is 0,1,...,N_CH-1,0,...
- Widths: rr_ptr is ID_W bits. Wrap from N_CH-1 to 0 is explicit, which matters for non-power-of-2 N_CH. Indices >= N_CH are never produced.

Optional Feature:
- Macro EDGE_ARB_SYNC_EN.
- When defined:
  - Each in bit passes through a 2-flop synchronizer, reset to 0, before the edge detector.
  - Input-to-evt_valid latency becomes 4 cycles.
  - Pulses narrower than one clock may be lost.
- When undefined: in drives the edge detector directly, with 2-cycle latency; in must already be synchronous to clk.

Test Plan:
- Reset and single event:
  - Stimulus: rst for 2 cycles; in[2] 0->1 at clock 5; evt_ready = 1.
  - Required: evt_valid = 1 and evt_id = 2 after clock 6; pending[2] = 0 after clock 7; no further events while in[2] stays high.
- Round-robin order:
  - Stimulus: rising edges on in[0], in[1] and in[3] at the same clock; evt_ready = 1.
  - Required: IDs delivered 0, 1, 3, spaced 2 cycles apart.
  - Repeat with rr_ptr = 2 (serve channel 1 first): required order 3, 0, 1.
- Backpressure:
  - Stimulus: event offered on channel 1; evt_ready = 0 for 5 cycles; meanwhile in[0] edges.
  - Required: evt_id stays 1 and evt_valid stays 1; channel 0 is delivered only after the channel 1 handshake.
- Overflow:
  - Stimulus: in[3] pulses 0-1-0-1 while evt_ready = 0 holds channel 3 in OFFER.
  - Required: overflow[3] = 1 and stays set after acceptance; clr_ovf pulse -> 0.
  - Clear-and-set in the same cycle -> overflow[3] remains 1.
- Same-cycle edge and accept:
  - Stimulus: second edge on the offered channel exactly at the handshake clock.
  - Required: pending stays 1, overflow stays 0, and the channel is re-offered after N_CH rotation.
- Reset mid-offer:
  - Stimulus: rst during OFFER with pending = 4'b1011.
  - Required: evt_valid = 0, pending = 0, overflow = 0 and rr_ptr = 0 the next cycle; an input held high re-triggers an event after rst deasserts.
